// File: rtl/bus_loader.sv
// bus_loader: boot loader that streams an image into mem from address 0,
// optionally reads it back against an 8-bit checksum, then releases the CPU.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   start               one-cycle load request, honoured in IDLE only
//   in_valid/in_data/   byte stream with handshake; in_last marks the
//   in_last/in_ready    final byte of the image
//   mar, data, we       memory address, tri-state data bus, write enable
//   cpu_reset           held high until the image is loaded (and verified)
//   len                 bytes loaded, 1..256
//   done, err           load complete / overflow or checksum mismatch
module bus_loader #(
  parameter int CHECK = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] mar,
  inout  wire  [7:0] data,
  output logic       we,
  output logic       cpu_reset,
  output logic [8:0] len,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLUSH,
    VERIFY,
    DONE,
    ERROR
  } state_t;

  state_t     state;
  state_t     nstate;
  logic [7:0] ptr;
  logic [7:0] lsum;
  logic [7:0] vsum;
  logic [7:0] vnext;
  logic [7:0] wdata;
  logic       hs;
  logic       last_rd;
  logic       in_ready_d;
  logic       done_d;
  logic       err_d;
  logic       cpu_reset_d;

  // Only drive the bus while writing so mem's read driver never fights us.
  assign data    = we ? wdata : 8'bzzzz_zzzz;

  assign hs      = (state == LOAD) && in_valid && in_ready;
  assign vnext   = vsum + data;
  assign last_rd = ({1'b0, mar} == (len - 9'd1));

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nstate;
    end
  end

  // Next-state logic
  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: begin
        if (start) nstate = LOAD;
      end
      LOAD: begin
        if (hs) begin
          if (in_last) nstate = FLUSH;
          else if (ptr == 8'hff) nstate = ERROR;
        end
      end
      FLUSH: begin
        nstate = (CHECK != 0) ? VERIFY : DONE;
      end
      VERIFY: begin
        // vnext already includes the byte read at this edge.
        if (last_rd) nstate = (vnext == lsum) ? DONE : ERROR;
      end
      DONE:    nstate = DONE;
      ERROR:   nstate = ERROR;
      default: nstate = IDLE;
    endcase
  end

  // Output logic: status flags follow the state being entered so they are
  // registered and valid in the same cycle as the new state.
  always_comb begin
    in_ready_d  = (nstate == LOAD);
    done_d      = (nstate == DONE);
    err_d       = (nstate == ERROR);
    cpu_reset_d = (nstate != DONE);
  end

  // Datapath and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      in_ready  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      cpu_reset <= 1'b1;
      we        <= 1'b0;
      mar       <= 8'd0;
      wdata     <= 8'd0;
      ptr       <= 8'd0;
      lsum      <= 8'd0;
      vsum      <= 8'd0;
      len       <= 9'd0;
    end else begin
      in_ready  <= in_ready_d;
      done      <= done_d;
      err       <= err_d;
      cpu_reset <= cpu_reset_d;
      we        <= hs;
      if ((state == IDLE) && start) begin
        ptr  <= 8'd0;
        lsum <= 8'd0;
        vsum <= 8'd0;
        len  <= 9'd0;
      end
      if (hs) begin
        wdata <= in_data;
        mar   <= ptr;
        lsum  <= lsum + in_data;
        ptr   <= ptr + 8'd1;
        len   <= {1'b0, ptr} + 9'd1;
      end
      if (state == FLUSH) begin
        mar <= 8'd0;
      end
      if (state == VERIFY) begin
        vsum <= vnext;
        mar  <= mar + 8'd1;
      end
    end
  end

endmodule
